// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU sequencer: state encodings and default width.
package div_sequencer_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_sequencer_step.sv
// One combinational radix-2 restoring division iteration on the {rem,quo} pair.
module div_sequencer_step
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   trial;
    logic             take;

    // rem < divisor on entry, so a set rem MSB means the shifted value exceeds any divisor;
    // the WIDTH-bit difference is then still exact, which keeps the subtract at WIDTH+1 bits.
    always_comb begin
        rem_sh   = {rem[WIDTH-2:0], quo[WIDTH-1]};
        trial    = {1'b0, rem_sh} - {1'b0, divisor};
        take     = rem[WIDTH-1] | ~trial[WIDTH];
        next_rem = take ? trial[WIDTH-1:0] : rem_sh;
        next_quo = {quo[WIDTH-2:0], take};
    end

endmodule

// File: rtl/div_sequencer.sv
// Execute-stage DIV/DIVU sequencer: WIDTH restoring steps, a sign-fix cycle, then a done pulse.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    div_state_e       state;
    div_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] raw_dvd;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             sign_q;
    logic             sign_r;
    logic             zero;
    logic             accept;

    div_sequencer_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dsr),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    always_comb begin
        accept = (state == DIV_IDLE || state == DIV_DONE) && start && !flush;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            DIV_IDLE: if (accept) state_next = DIV_RUN;
            DIV_RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_next = DIV_FIX;
            end
            DIV_FIX: begin
                busy       = 1'b1;
                state_next = DIV_DONE;
            end
            DIV_DONE: begin
                done       = 1'b1;
                state_next = accept ? DIV_RUN : DIV_IDLE;
            end
            default: state_next = DIV_IDLE;
        endcase
        // The issue cycle itself must stall the pipeline.
        if (accept) busy = 1'b1;
        if (flush) state_next = DIV_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= DIV_IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dsr     <= '0;
            raw_dvd <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            zero    <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            dsr     <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
            raw_dvd <= dividend;
            sign_q  <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r  <= is_signed && dividend[WIDTH-1];
            zero    <= (divisor == '0);
        end else if (state == DIV_RUN && !flush) begin
            cnt <= cnt + 1'b1;
            rem <= step_rem;
            quo <= step_quo;
        end
    end

    // Outputs only change when a divide completes; a flushed divide leaves them untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == DIV_FIX && !flush) begin
            if (zero) begin
                quotient    <= '1;
                remainder   <= raw_dvd;
                div_by_zero <= 1'b1;
            end else begin
                quotient    <= sign_q ? -quo : quo;
                remainder   <= sign_r ? -rem : rem;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule
